// File: rtl/vga_sync_decoder.sv
// VGA input decoder: measures line/frame timing from hsync/vsync, acquires lock, and
// emits 2:1 downsampled frame-buffer writes for the active window once locked.
module vga_sync_decoder #(
    parameter int H_ACT_BEGIN = 143,
    parameter int V_ACT_BEGIN = 34,
    parameter int H_CAP       = 320,
    parameter int V_CAP       = 240,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       pix_en,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] rgb_in,
    output logic       locked,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       pix_we,
    output logic [8:0] pix_x,
    output logic [7:0] pix_y,
    output logic [2:0] pix_rgb
);

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_TRACK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [9:0] CNT_MAX = 10'd1023;
    localparam logic [9:0] H_BEG   = 10'(H_ACT_BEGIN);
    localparam logic [9:0] V_BEG   = 10'(V_ACT_BEGIN);
    localparam logic [9:0] H_SPAN  = 10'(2 * H_CAP);
    localparam logic [9:0] V_SPAN  = 10'(2 * V_CAP);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;
    logic       vpend_q, vpend_d;
    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic [9:0] line_len_q, line_len_d;
    logic [9:0] frame_lines_q, frame_lines_d;
    logic [1:0] state_q, state_d;
    logic [9:0] ref_len_q, ref_len_d;
    logic [9:0] ref_lines_q, ref_lines_d;
    logic [7:0] match_q, match_d;
    logic       locked_q, locked_d;
    logic       we_q, we_d;
    logic [8:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [2:0] rgb_q, rgb_d;

    logic       line_start, vfall, frame_start, sat;
    logic [9:0] dh, dv;

    assign line_start  = pix_en & ~hsync_in & hs_prev_q;
    assign vfall       = pix_en & ~vsync_in & vs_prev_q;
    // A vsync fall in the same sample as the hsync fall starts the frame immediately.
    assign frame_start = line_start & (vpend_q | vfall);

    always_comb begin
        hs_prev_d     = hs_prev_q;
        vs_prev_d     = vs_prev_q;
        vpend_d       = vpend_q;
        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;
        if (pix_en) begin
            hs_prev_d = hsync_in;
            vs_prev_d = vsync_in;
            if (line_start) begin
                hcount_d   = 10'd0;
                line_len_d = hcount_q + 10'd1;
            end else if (hcount_q != CNT_MAX) begin
                hcount_d = hcount_q + 10'd1;
            end
            if (frame_start) begin
                vcount_d      = 10'd0;
                vpend_d       = 1'b0;
                frame_lines_d = vcount_q + 10'd1;
            end else begin
                if (line_start && vcount_q != CNT_MAX) vcount_d = vcount_q + 10'd1;
                if (vfall) vpend_d = 1'b1;
            end
        end
    end

    assign sat = (hcount_d == CNT_MAX) | (vcount_d == CNT_MAX);
    // Offsets wrap on underflow, so pixels before the window fail the span check.
    assign dh  = hcount_d - H_BEG;
    assign dv  = vcount_d - V_BEG;

    always_comb begin
        state_d     = state_q;
        ref_len_d   = ref_len_q;
        ref_lines_d = ref_lines_q;
        match_d     = match_q;
        we_d        = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        rgb_d       = rgb_q;
        if (pix_en) begin
            case (state_q)
                ST_SEARCH: begin
                    if (frame_start) begin
                        ref_len_d   = line_len_d;
                        ref_lines_d = frame_lines_d;
                        match_d     = 8'd0;
                        state_d     = ST_TRACK;
                    end
                end
                ST_TRACK: begin
                    if (sat) begin
                        state_d = ST_SEARCH;
                    end else if (frame_start) begin
                        if (line_len_d == ref_len_q && frame_lines_d == ref_lines_q) begin
                            match_d = match_q + 8'd1;
                            if (match_d == LOCK_N) state_d = ST_LOCKED;
                        end else begin
                            ref_len_d   = line_len_d;
                            ref_lines_d = frame_lines_d;
                            match_d     = 8'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (sat || (line_start && line_len_d != ref_len_q)
                            || (frame_start && frame_lines_d != ref_lines_q))
                        state_d = ST_SEARCH;
                end
                default: state_d = ST_SEARCH;
            endcase
            if (locked_q && dh < H_SPAN && dv < V_SPAN && !dh[0] && !dv[0]) begin
                we_d  = 1'b1;
                x_d   = dh[9:1];
                y_d   = dv[8:1];
                rgb_d = rgb_in;
            end
        end
    end

    assign locked_d = (state_d == ST_LOCKED);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hs_prev_q     <= 1'b0;
            vs_prev_q     <= 1'b0;
            vpend_q       <= 1'b0;
            hcount_q      <= 10'd0;
            vcount_q      <= 10'd0;
            line_len_q    <= 10'd0;
            frame_lines_q <= 10'd0;
            state_q       <= ST_SEARCH;
            ref_len_q     <= 10'd0;
            ref_lines_q   <= 10'd0;
            match_q       <= 8'd0;
            locked_q      <= 1'b0;
            we_q          <= 1'b0;
            x_q           <= 9'd0;
            y_q           <= 8'd0;
            rgb_q         <= 3'd0;
        end else begin
            hs_prev_q     <= hs_prev_d;
            vs_prev_q     <= vs_prev_d;
            vpend_q       <= vpend_d;
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            state_q       <= state_d;
            ref_len_q     <= ref_len_d;
            ref_lines_q   <= ref_lines_d;
            match_q       <= match_d;
            locked_q      <= locked_d;
            we_q          <= we_d;
            x_q           <= x_d;
            y_q           <= y_d;
            rgb_q         <= rgb_d;
        end
    end

    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign frame_lines = frame_lines_q;
    assign pix_we      = we_q;
    assign pix_x       = x_q;
    assign pix_y       = y_q;
    assign pix_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder: a reduced-geometry VGA source with random pixel enables,
// checked every clock against a sample-indexed behavioural model plus scenario checks.
module tb_vga_sync_decoder;

    localparam int HT = 40;   // samples per line
    localparam int HS = 6;    // hsync low samples
    localparam int VT = 24;   // lines per frame
    localparam int VS = 2;    // vsync low lines
    localparam int HB = 10;
    localparam int VB = 4;
    localparam int HC = 12;
    localparam int VC = 8;
    localparam int LF = 2;

    logic       clock = 1'b0;
    logic       reset_n, pix_en, hsync_in, vsync_in;
    logic [2:0] rgb_in;
    logic       locked, pix_we;
    logic [9:0] line_len, frame_lines;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [2:0] pix_rgb;

    always #10 clock = ~clock;

    vga_sync_decoder #(
        .H_ACT_BEGIN(HB), .V_ACT_BEGIN(VB), .H_CAP(HC), .V_CAP(VC), .LOCK_FRAMES(LF)
    ) dut (
        .clock(clock), .reset_n(reset_n), .pix_en(pix_en), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .rgb_in(rgb_in), .locked(locked), .line_len(line_len),
        .frame_lines(frame_lines), .pix_we(pix_we), .pix_x(pix_x), .pix_y(pix_y),
        .pix_rgb(pix_rgb)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Source generator state
    int sh, sv, short_line, hold_hs, pe_low;
    bit rst_req;
    bit s_ok;
    int s_h, s_v;
    logic lk_prev;

    // Reference model state: positions are counted in samples since reset
    int m_smp, m_last_ls, m_lines;
    bit m_hp, m_vp, m_vpend;
    int m_llen, m_fl, m_rl, m_rf, m_match;
    bit m_have, m_lk, m_we;
    int m_x, m_y, m_rgb;

    function automatic int cap1023(input int a);
        return (a > 1023) ? 1023 : a;
    endfunction

    task automatic model(input logic rn, input logic pe, input logic hs, input logic vs,
                         input logic [2:0] c);
        int h_old, v_old, h_new, v_new, dh, dv;
        bit ls, vf, fs, sat;
        if (!rn) begin
            m_smp = 0; m_last_ls = 0; m_lines = 0;
            m_hp = 0; m_vp = 0; m_vpend = 0;
            m_llen = 0; m_fl = 0; m_rl = 0; m_rf = 0; m_match = 0;
            m_have = 0; m_lk = 0; m_we = 0; m_x = 0; m_y = 0; m_rgb = 0;
            return;
        end
        m_we = 0;
        if (!pe) return;
        h_old = cap1023(m_smp - m_last_ls);
        v_old = cap1023(m_lines);
        m_smp++;
        ls = !hs && m_hp;
        vf = !vs && m_vp;
        fs = ls && (m_vpend || vf);
        m_hp = hs;
        m_vp = vs;
        if (ls) begin
            m_llen = (h_old + 1) % 1024;
            m_last_ls = m_smp;
        end
        if (fs) begin
            m_fl = (v_old + 1) % 1024;
            m_lines = 0;
            m_vpend = 0;
        end else begin
            if (ls) m_lines++;
            if (vf) m_vpend = 1;
        end
        h_new = cap1023(m_smp - m_last_ls);
        v_new = cap1023(m_lines);
        dh = (h_new - HB) & 1023;
        dv = (v_new - VB) & 1023;
        if (m_lk && dh < 2*HC && dv < 2*VC && dh % 2 == 0 && dv % 2 == 0) begin
            m_we = 1; m_x = dh / 2; m_y = dv / 2; m_rgb = int'(c);
        end
        sat = (h_new == 1023) || (v_new == 1023);
        if (fs) begin
            if (!m_have) begin
                m_have = 1; m_rl = m_llen; m_rf = m_fl; m_match = 0;
            end else if (!m_lk) begin
                if (m_llen == m_rl && m_fl == m_rf) begin
                    m_match++;
                    if (m_match >= LF) m_lk = 1;
                end else begin
                    m_rl = m_llen; m_rf = m_fl; m_match = 0;
                end
            end else if (m_fl != m_rf) begin
                m_have = 0; m_lk = 0;
            end
        end
        if (m_lk && ls && m_llen != m_rl) begin m_have = 0; m_lk = 0; end
        if (sat && m_have) begin m_have = 0; m_lk = 0; end
    endtask

    task automatic step();
        logic pe, hs, vs;
        logic [2:0] c;
        logic [41:0] exp_v;
        int len;
        @(negedge clock);
        lk_prev = locked;
        pe = (pe_low > 0) ? 1'b0 : 1'($urandom_range(0, 1));
        if (pe_low > 0) pe_low--;
        hs = (sh >= HS);
        vs = (sv >= VS);
        if (hold_hs > 0) hs = 1'b1;
        c = 3'(sh ^ sv);
        reset_n = !rst_req; pix_en = pe; hsync_in = hs; vsync_in = vs; rgb_in = c;
        s_ok = reset_n && pe;
        s_h = sh;
        s_v = sv;
        @(posedge clock);
        model(reset_n, pe, hs, vs, c);
        #1;
        exp_v = {m_lk, 10'(m_llen), 10'(m_fl), m_we, 9'(m_x), 8'(m_y), 3'(m_rgb)};
        chk_eq("cycle", {locked, line_len, frame_lines, pix_we, pix_x, pix_y, pix_rgb}, exp_v);
        if (s_ok) begin
            if (hold_hs > 0) hold_hs--;
            len = (sv == short_line) ? 30 : HT;
            sh++;
            if (sh >= len) begin
                sh = 0;
                if (sv == short_line) short_line = -1;
                sv = (sv + 1) % VT;
            end
        end
    endtask

    task automatic run_to(input int h, input int v, input int budget, input string tag);
        bit hit = 0;
        for (int i = 0; i < budget && !hit; i++) begin
            step();
            if (s_ok && s_h == h && s_v == v) hit = 1;
        end
        if (!hit) chk_eq(tag, 0, 1);
    endtask

    task automatic run_to_lock(input int budget, output int wraps, output int wes);
        bit done = 0;
        wraps = 0;
        wes = 0;
        for (int i = 0; i < budget && !done; i++) begin
            step();
            if (s_ok && s_h == 0 && s_v == 0) wraps++;
            if (pix_we) wes++;
            if (locked) done = 1;
        end
    endtask

    initial begin
        int wraps, wes, rise, nwr, lowcnt, saved;
        int fx, fy, frgb, lx, ly, lrgb;
        bit done;
        reset_n = 1'b0; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1; rgb_in = 3'd0;
        sh = 1; sv = 0; short_line = -1; hold_hs = 0; pe_low = 0; rst_req = 1;
        repeat (3) step();
        chk_eq("reset_out", {locked, line_len, frame_lines, pix_we, pix_x, pix_y, pix_rgb}, 0);
        rst_req = 0;

        // Acquisition from a clean stream
        wraps = 0; rise = 0;
        for (int i = 0; i < 20000 && rise == 0; i++) begin
            step();
            if (s_ok && s_h == 0 && s_v == 0) wraps++;
            if (locked && !lk_prev) rise = wraps;
        end
        chk_eq("lock_wrap", rise, 3);
        chk_eq("line_len", line_len, HT);
        chk_eq("frame_lines", frame_lines, VT);

        // One full locked frame of writes
        run_to(0, 0, 6000, "tmo_wrap2");
        nwr = 0; lowcnt = 0; done = 0;
        fx = -1; fy = -1; frgb = -1; lx = -1; ly = -1; lrgb = -1;
        for (int i = 0; i < 6000 && !done; i++) begin
            step();
            if (pix_we) begin
                if (nwr == 0) begin fx = pix_x; fy = pix_y; frgb = pix_rgb; end
                lx = pix_x; ly = pix_y; lrgb = pix_rgb;
                nwr++;
            end
            if (!locked) lowcnt++;
            if (s_ok && s_h == 0 && s_v == 0) done = 1;
        end
        chk_eq("frame_writes", nwr, HC * VC);
        chk_eq("lock_held", lowcnt, 0);
        chk_eq("first_xy", {fx[15:0], fy[15:0]}, 0);
        chk_eq("first_rgb", frgb, (HB ^ VB) & 7);
        chk_eq("last_xy", {lx[15:0], ly[15:0]}, {16'(HC - 1), 16'(VC - 1)});
        chk_eq("last_rgb", lrgb, ((HB + 2*HC - 2) ^ (VB + 2*VC - 2)) & 7);

        // Shortened line breaks lock at the following line start
        short_line = 10;
        run_to(0, 11, 6000, "tmo_short");
        chk_eq("short_pre", lk_prev, 1);
        chk_eq("short_drop", locked, 0);
        run_to_lock(20000, wraps, wes);
        chk_eq("relock_wraps", wraps, 3);

        // hsync stuck high: counter saturation
        run_to(0, 0, 6000, "tmo_wrap3");
        hold_hs = 1100; wes = 0;
        for (int i = 0; i < 6000 && hold_hs > 0; i++) begin
            step();
            if (pix_we) wes++;
        end
        chk_eq("sat_unlock", locked, 0);
        chk_eq("sat_no_we", wes, 0);
        run_to_lock(30000, wraps, wes);
        chk_eq("sat_reacq", locked, 1);

        // Reset pulse during active video
        run_to(20, 10, 6000, "tmo_mid");
        rst_req = 1;
        step();
        rst_req = 0;
        chk_eq("rst_mid", {locked, line_len, frame_lines, pix_we, pix_x, pix_y, pix_rgb}, 0);
        run_to_lock(30000, wraps, wes);
        chk_eq("rst_no_we", wes, 0);
        chk_eq("rst_relock", locked, 1);

        // pix_en held low mid-line
        run_to(15, 10, 6000, "tmo_pe");
        saved = line_len;
        pe_low = 20;
        repeat (20) step();
        chk_eq("pe_lock", locked, 1);
        chk_eq("pe_len", line_len, saved);
        run_to(0, 11, 2000, "tmo_pe2");
        chk_eq("pe_next_len", line_len, HT);
        chk_eq("pe_lock2", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
